// File: rtl/tty_input.sv
// tty_input: console input buffer, the receiving side of the tty output block.
// The host side pushes ASCII characters into a circular FIFO. The CPU pops
// them one at a time, with first-word fall-through on data. The block also
// counts buffered line terminators and keeps a sticky flag for dropped pushes.
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   key_data[7:0]  in   character from the host side
//   key_valid      in   push strobe, one character per high cycle
//   read           in   CPU pop strobe, consumes the character on data
//   clear_overflow in   clears the sticky overflow flag
//   data[7:0]      out  head character, 0 when empty (combinational from head)
//   ready          out  FIFO holds at least one character
//   full           out  count == DEPTH
//   count          out  buffered characters, 0..DEPTH
//   lines          out  buffered NEWLINE characters
//   overflow       out  sticky, set when a push is dropped
module tty_input #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ADDR_W  = 4,
    parameter logic [7:0]  NEWLINE = 8'd10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        key_data,
    input  logic              key_valid,
    input  logic              read,
    input  logic              clear_overflow,
    output logic [7:0]        data,
    output logic              ready,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W:0]   lines,
    output logic              overflow
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Storage and registered FIFO state
    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [CNT_W-1:0]  lines_q,  lines_d;
    logic              overflow_q, overflow_d;

    // Per-cycle decisions
    logic       empty_c;
    logic       full_c;
    logic       push_c;
    logic       pop_c;
    logic       drop_c;
    logic [7:0] head_c;
    logic       push_nl_c;
    logic       pop_nl_c;

    // Status derived from the registered count
    always_comb begin
        empty_c = (count_q == '0);
        full_c  = (count_q == DEPTH_C);
        head_c  = mem_q[rd_ptr_q];
    end

    // Accept/drop decisions; a read on a full FIFO frees the slot the push needs
    always_comb begin
        pop_c     = read && !empty_c;
        push_c    = key_valid && (!full_c || read);
        drop_c    = key_valid && full_c && !read;
        push_nl_c = push_c && (key_data == NEWLINE);
        pop_nl_c  = pop_c && (head_c == NEWLINE);
    end

    // Next-state for pointers, occupancy, line count and overflow
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        lines_d    = lines_q;
        overflow_d = overflow_q;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        if (push_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_c && !push_c) begin
            count_d = count_q - CNT_W'(1);
        end

        if (push_nl_c && !pop_nl_c) begin
            lines_d = lines_q + CNT_W'(1);
        end else if (pop_nl_c && !push_nl_c) begin
            lines_d = lines_q - CNT_W'(1);
        end

        // Set has priority over clear in the same cycle
        if (clear_overflow) begin
            overflow_d = 1'b0;
        end
        if (drop_c) begin
            overflow_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            lines_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            lines_q    <= lines_d;
            overflow_q <= overflow_d;
        end
    end

    // Character storage; contents are not reset
    always_ff @(posedge clock) begin
        if (!reset && push_c) begin
            mem_q[wr_ptr_q] <= key_data;
        end
    end

    // Outputs
    always_comb begin
        data     = empty_c ? 8'd0 : head_c;
        ready    = !empty_c;
        full     = full_c;
        count    = count_q;
        lines    = lines_q;
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_tty_input.sv
// Directed bench for tty_input: inputs change 1ns after the rising edge, and
// outputs are checked in that same window.
module tb_tty_input;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] key_data = 8'd0;
    logic       key_valid = 1'b0;
    logic       read = 1'b0;
    logic       clear_overflow = 1'b0;
    logic [7:0] data;
    logic       ready;
    logic       full;
    logic [4:0] count;
    logic [4:0] lines;
    logic       overflow;

    int checks = 0;
    int failures = 0;

    tty_input #(.DEPTH(16), .ADDR_W(4), .NEWLINE(8'd10)) dut (
        .clock          (clock),
        .reset          (reset),
        .key_data       (key_data),
        .key_valid      (key_valid),
        .read           (read),
        .clear_overflow (clear_overflow),
        .data           (data),
        .ready          (ready),
        .full           (full),
        .count          (count),
        .lines          (lines),
        .overflow       (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] c);
        key_data  = c;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check(tag, 32'(data), 32'(exp));
        read = 1'b1;
        step();
        read = 1'b0;
    endtask

    logic [7:0] model_q[$];

    initial begin
        // Reset state
        step();
        step();
        reset = 1'b0;
        check("rst_count", 32'(count), 0);
        check("rst_ready", 32'(ready), 0);
        check("rst_full", 32'(full), 0);
        check("rst_data", 32'(data), 0);
        check("rst_lines", 32'(lines), 0);
        check("rst_ovf", 32'(overflow), 0);

        // Five characters in, five out
        for (int i = 0; i < 5; i++) push(8'(49 + i));
        check("seq_count5", 32'(count), 5);
        check("seq_ready", 32'(ready), 1);
        for (int i = 0; i < 5; i++) pop_expect("seq_data", 8'(49 + i));
        check("seq_count0", 32'(count), 0);
        check("seq_ready0", 32'(ready), 0);
        check("seq_data0", 32'(data), 0);

        // Line counting
        push(8'd65);
        push(8'd66);
        push(8'd10);
        check("ln_lines1", 32'(lines), 1);
        check("ln_count3", 32'(count), 3);
        pop_expect("ln_a", 8'd65);
        pop_expect("ln_b", 8'd66);
        check("ln_lines_before_nl", 32'(lines), 1);
        pop_expect("ln_nl", 8'd10);
        check("ln_lines0", 32'(lines), 0);

        // Fill, drop a push, clear overflow
        for (int i = 0; i < 16; i++) push(8'(97 + i));
        check("fill_full", 32'(full), 1);
        check("fill_count", 32'(count), 16);
        check("fill_ovf0", 32'(overflow), 0);
        push(8'd88);
        check("drop_ovf", 32'(overflow), 1);
        check("drop_count", 32'(count), 16);
        check("drop_full", 32'(full), 1);
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        check("clr_ovf", 32'(overflow), 0);
        // Drop and clear together: set wins
        key_data = 8'd88;
        key_valid = 1'b1;
        clear_overflow = 1'b1;
        step();
        key_valid = 1'b0;
        clear_overflow = 1'b0;
        check("setwins_ovf", 32'(overflow), 1);
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        for (int i = 0; i < 16; i++) pop_expect("drop_drain", 8'(97 + i));
        check("drop_empty", 32'(count), 0);

        // Push and pop together while full
        for (int i = 0; i < 16; i++) push(8'(65 + i));
        check("fp_head", 32'(data), 65);
        key_data = 8'd90;
        key_valid = 1'b1;
        read = 1'b1;
        step();
        key_valid = 1'b0;
        read = 1'b0;
        check("fp_count", 32'(count), 16);
        check("fp_ovf", 32'(overflow), 0);
        check("fp_full", 32'(full), 1);
        for (int i = 1; i < 16; i++) pop_expect("fp_drain", 8'(65 + i));
        pop_expect("fp_last", 8'd90);
        check("fp_empty", 32'(count), 0);

        // Push and pop together while empty
        key_data = 8'd65;
        key_valid = 1'b1;
        read = 1'b1;
        step();
        key_valid = 1'b0;
        read = 1'b0;
        check("ep_count", 32'(count), 1);
        check("ep_data", 32'(data), 65);
        pop_expect("ep_pop", 8'd65);
        // Read on empty is ignored
        read = 1'b1;
        step();
        read = 1'b0;
        check("ur_count", 32'(count), 0);
        check("ur_ready", 32'(ready), 0);
        push(8'd67);
        check("ur_data", 32'(data), 67);
        check("ur_count1", 32'(count), 1);
        pop_expect("ur_pop", 8'd67);

        // Pointer wrap with interleaved reads
        model_q.delete();
        for (int i = 0; i < 24; i++) begin
            key_data = 8'(48 + i);
            key_valid = 1'b1;
            if (i % 3 == 2) begin
                check("wr_head", 32'(data), 32'(model_q[0]));
                void'(model_q.pop_front());
                read = 1'b1;
            end
            model_q.push_back(8'(48 + i));
            step();
            key_valid = 1'b0;
            read = 1'b0;
        end
        check("wr_count", 32'(count), 16);
        for (int i = 0; i < 16; i++) pop_expect("wr_drain", model_q[i]);
        check("wr_empty", 32'(count), 0);

        // Reset mid-stream
        push(8'd120);
        push(8'd10);
        push(8'd121);
        push(8'd10);
        push(8'd122);
        push(8'd119);
        push(8'd118);
        check("mr_count7", 32'(count), 7);
        check("mr_lines2", 32'(lines), 2);
        reset = 1'b1;
        key_data = 8'd10;
        key_valid = 1'b1;
        step();
        reset = 1'b0;
        key_valid = 1'b0;
        check("mr_count", 32'(count), 0);
        check("mr_lines", 32'(lines), 0);
        check("mr_ready", 32'(ready), 0);
        check("mr_data", 32'(data), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tty_input.md
Name: tty_input

Overview:
- Keyboard/console input device: the receiving counterpart of the tty output block.
- A host-side source (bench or UART front end) pushes 8-bit ASCII characters. They are buffered in an on-chip FIFO.
- The CPU drains the FIFO one character per read strobe.
- The block also tracks how many complete lines (LF-terminated) are buffered, for line-mode polling, and flags dropped characters.

Parameters:
- DEPTH, 16, FIFO capacity in characters; must be a power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH); pointer width.
- NEWLINE, 8'd10, character code that terminates a line.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- key_data  input  8  character from the host side.
- key_valid  input  1  push strobe; one character per cycle in which it is high.
- read  input  1  CPU pop strobe; consumes the character currently on data.
- clear_overflow  input  1  clears the sticky overflow flag.
- data  output  8  head-of-FIFO character (first-word fall-through); 8'd0 when empty.
- ready  output  1  high when the FIFO holds at least one character.
- full  output  1  high when count == DEPTH.
- count  output  ADDR_W+1  number of buffered characters, 0..DEPTH.
- lines  output  ADDR_W+1  number of NEWLINE characters currently buffered.
- overflow  output  1  sticky; set when a push is dropped.

Behaviour:
- Reset: synchronous on clock edge with reset=1. Pointers and count go to 0, lines=0, overflow=0, so ready=0, full=0, data=8'd0. Memory contents are don't-care.
- Reset takes priority over every other input in the same cycle. A push or read coincident with reset is discarded, and reset mid-stream empties the buffer.
- Storage: circular buffer with rd_ptr and wr_ptr (ADDR_W bits each), wrapping modulo DEPTH. count is held in a separate register, and full/empty derive from count.
- Output path: data = mem[rd_ptr] combinationally whenever count>0, otherwise 8'd0. A character written at edge N is visible on data and ready after edge N, with zero-cycle read latency.
- Push accepted when key_valid=1 and (count<DEPTH, or count==DEPTH with read=1 in the same cycle). On accept: write mem[wr_ptr], then wr_ptr+1.
- Push dropped when key_valid=1, count==DEPTH and read=0. In that case overflow is set to 1 and no state other than overflow changes.
- Pop accepted when read=1 and count>0: rd_ptr+1. A read while empty is ignored, with no underflow and no flag.
- Simultaneous push and pop, count>0: both happen and count is unchanged.
- Simultaneous push and pop, count==0: only the push happens, count becomes 1, and data shows the new character next cycle.
- Simultaneous push and pop, count==DEPTH: both happen, count stays DEPTH, and overflow is not set.
- count update: +1 on push only, -1 on pop only, unchanged when both or neither happen.
- lines: +1 when an accepted push carries NEWLINE, and -1 when an accepted pop removes a NEWLINE (data==NEWLINE). Both in the same cycle leave it unchanged. lines never exceeds count.
- overflow: set by a dropped push and cleared by clear_overflow=1. If both happen in the same cycle, set wins.
- No internal FSM beyond the FIFO state. All outputs except data are registered or derived from registered count.

Test Plan:
- Reset, then push 8'd49..8'd53 on consecutive cycles, then read 5 times → data sequence 49,50,51,52,53. count goes 5→0, ready falls after the 5th read, and data=0.
- Push "AB\n" (65,66,10) → lines=1, count=3. Read 3 times → lines=0 after the read where data==10.
- Fill 16 chars, then push 8'd88 with read=0 → full=1, overflow=1, count=16, and 88 is absent on drain. Then pulse clear_overflow → overflow=0.
- Full FIFO with key_valid=1 (data 8'd90) and read=1 in the same cycle → count stays 16, overflow stays 0, and 90 comes out last on drain.
- Empty FIFO with push 8'd65 and read=1 in the same cycle → count=1, data=65 next cycle. Read on empty → no change to count or pointers.
- Push 24 chars with 8 interleaved reads so the pointers wrap → FIFO order preserved across the wrap. Assert reset with count=7 and lines=2 → count=0, lines=0, ready=0, data=0 next cycle.
